// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/exe/mem/wb hazard inputs plus the stage-control,
// forwarding and stall-counter outputs. The slave modport belongs to the controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW      = 5,
    parameter int FWD_W       = 2,
    parameter int STALL_CNT_W = 16
);
    logic [REG_AW-1:0]      id_rs1;
    logic [REG_AW-1:0]      id_rs2;
    logic                   id_rs1_en;
    logic                   id_rs2_en;
    logic [REG_AW-1:0]      ex_rd;
    logic                   ex_we;
    logic                   ex_is_load;
    logic                   ex_busy;
    logic                   ex_redirect;
    logic [REG_AW-1:0]      mem_rd;
    logic                   mem_we;
    logic [REG_AW-1:0]      wb_rd;
    logic                   wb_we;
    logic                   icache_miss;
    logic                   pc_en;
    logic                   fd_en;
    logic                   fd_flush;
    logic                   de_en;
    logic                   de_flush;
    logic                   em_en;
    logic                   mw_en;
    logic                   mw_flush;
    logic [FWD_W-1:0]       fwd_sel1;
    logic [FWD_W-1:0]       fwd_sel2;
    logic [STALL_CNT_W-1:0] lu_stall_cnt;
    logic [STALL_CNT_W-1:0] miss_stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_en, id_rs2_en, ex_rd, ex_we, ex_is_load,
               ex_busy, ex_redirect, mem_rd, mem_we, wb_rd, wb_we, icache_miss,
        input  pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_flush,
               fwd_sel1, fwd_sel2, lu_stall_cnt, miss_stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_en, id_rs2_en, ex_rd, ex_we, ex_is_load,
               ex_busy, ex_redirect, mem_rd, mem_we, wb_rd, wb_we, icache_miss,
        output pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_flush,
               fwd_sel1, fwd_sel2, lu_stall_cnt, miss_stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard/control: stage enables and flushes, EXE forwarding, load-use
// interlock, I-cache miss freeze/replay. Stall counters exist only with PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int FWD_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              nrst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MISS   = 2'd1,
        REPLAY = 2'd2
    } state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic [1:0][REG_AW-1:0] id_rs;
    logic [1:0]             id_rs_en;
    logic [1:0][REG_AW-1:0] ex_rs_q;
    logic [1:0][REG_AW-1:0] ex_rs_d;
    logic [1:0][FWD_W-1:0]  fwd_sel;
    logic [1:0]             rs_hit;
    logic                   lu;
    logic                   lu_cyc;
    logic                   miss_cyc;

    assign id_rs    = {bus.id_rs2, bus.id_rs1};
    assign id_rs_en = {bus.id_rs2_en, bus.id_rs1_en};

    // Per operand: EXE source copy, forwarding select (MEM beats WB, x0 never) and load-use match
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            assign ex_rs_d[gi] = bus.de_flush ? '0 : (bus.de_en ? id_rs[gi] : ex_rs_q[gi]);
            assign fwd_sel[gi] =
                (bus.mem_we && (bus.mem_rd != '0) && (bus.mem_rd == ex_rs_q[gi])) ? FWD_W'(2) :
                (bus.wb_we  && (bus.wb_rd  != '0) && (bus.wb_rd  == ex_rs_q[gi])) ? FWD_W'(1) :
                '0;
            assign rs_hit[gi] = id_rs_en[gi] && (id_rs[gi] == bus.ex_rd);
        end
    endgenerate

    assign bus.fwd_sel1 = fwd_sel[0];
    assign bus.fwd_sel2 = fwd_sel[1];
    assign lu = bus.ex_is_load && bus.ex_we && (bus.ex_rd != '0) && (|rs_hit);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= RUN;
            ex_rs_q <= '0;
        end else begin
            state_q <= state_d;
            ex_rs_q <= ex_rs_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.pc_en    = 1'b1;
        bus.fd_en    = 1'b1;
        bus.fd_flush = 1'b0;
        bus.de_en    = 1'b1;
        bus.de_flush = 1'b0;
        bus.em_en    = 1'b1;
        bus.mw_en    = 1'b1;
        bus.mw_flush = 1'b0;
        lu_cyc       = 1'b0;
        miss_cyc     = 1'b0;
        if (bus.ex_busy) begin
            // Drain MEM into WB as a bubble; everything upstream waits, FSM frozen
            bus.pc_en    = 1'b0;
            bus.fd_en    = 1'b0;
            bus.de_en    = 1'b0;
            bus.em_en    = 1'b0;
            bus.mw_flush = 1'b1;
        end else if (bus.ex_redirect) begin
            bus.fd_flush = 1'b1;
            bus.de_flush = 1'b1;
            state_d      = RUN;
        end else if ((state_q == MISS) || ((state_q == RUN) && bus.icache_miss)) begin
            bus.pc_en = 1'b0;
            bus.fd_en = 1'b0;
            bus.de_en = 1'b0;
            bus.em_en = 1'b0;
            bus.mw_en = 1'b0;
            miss_cyc  = 1'b1;
            state_d   = bus.icache_miss ? MISS : ((state_q == MISS) ? REPLAY : RUN);
        end else if (state_q == REPLAY) begin
            // FETCH->DECODE takes the refilled word while EXE gets a bubble
            bus.pc_en    = 1'b0;
            bus.de_flush = 1'b1;
            miss_cyc     = 1'b1;
            state_d      = RUN;
        end else if (lu) begin
            bus.pc_en    = 1'b0;
            bus.fd_en    = 1'b0;
            bus.de_flush = 1'b1;
            lu_cyc       = 1'b1;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [STALL_CNT_W-1:0] lu_cnt_q;
    logic [STALL_CNT_W-1:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            lu_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lu_cyc && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + 1'b1;
            end
            if (miss_cyc && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign bus.lu_stall_cnt   = lu_cnt_q;
    assign bus.miss_stall_cnt = miss_cnt_q;
`else
    logic unused_perf;
    assign unused_perf        = lu_cyc ^ miss_cyc;
    assign bus.lu_stall_cnt   = '0;
    assign bus.miss_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus a 4-bit-counter instance
// sharing the same stimulus for the saturation case.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    // {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, mw_flush}
    localparam logic [7:0] C_NORMAL = 8'hD6;
    localparam logic [7:0] C_BUSY   = 8'h03;
    localparam logic [7:0] C_REDIR  = 8'hFE;
    localparam logic [7:0] C_FROZEN = 8'h00;
    localparam logic [7:0] C_REPLAY = 8'h5E;
    localparam logic [7:0] C_LU     = 8'h1E;

    logic       clk = 1'b0;
    logic       nrst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_rs1_en, id_rs2_en, ex_we, ex_is_load, ex_busy, ex_redirect;
    logic       mem_we, wb_we, icache_miss;
    logic [7:0] ctl;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus ();
    pipe_hazard_ctrl_if #(.STALL_CNT_W(4)) bus_sat ();

    pipe_hazard_ctrl dut (.clk(clk), .nrst(nrst), .bus(bus));
    pipe_hazard_ctrl #(.STALL_CNT_W(4)) dut_sat (.clk(clk), .nrst(nrst), .bus(bus_sat));

    assign bus.id_rs1 = id_rs1;           assign bus_sat.id_rs1 = id_rs1;
    assign bus.id_rs2 = id_rs2;           assign bus_sat.id_rs2 = id_rs2;
    assign bus.id_rs1_en = id_rs1_en;     assign bus_sat.id_rs1_en = id_rs1_en;
    assign bus.id_rs2_en = id_rs2_en;     assign bus_sat.id_rs2_en = id_rs2_en;
    assign bus.ex_rd = ex_rd;             assign bus_sat.ex_rd = ex_rd;
    assign bus.ex_we = ex_we;             assign bus_sat.ex_we = ex_we;
    assign bus.ex_is_load = ex_is_load;   assign bus_sat.ex_is_load = ex_is_load;
    assign bus.ex_busy = ex_busy;         assign bus_sat.ex_busy = ex_busy;
    assign bus.ex_redirect = ex_redirect; assign bus_sat.ex_redirect = ex_redirect;
    assign bus.mem_rd = mem_rd;           assign bus_sat.mem_rd = mem_rd;
    assign bus.mem_we = mem_we;           assign bus_sat.mem_we = mem_we;
    assign bus.wb_rd = wb_rd;             assign bus_sat.wb_rd = wb_rd;
    assign bus.wb_we = wb_we;             assign bus_sat.wb_we = wb_we;
    assign bus.icache_miss = icache_miss; assign bus_sat.icache_miss = icache_miss;

    assign ctl = {bus.pc_en, bus.fd_en, bus.fd_flush, bus.de_en,
                  bus.de_flush, bus.em_en, bus.mw_en, bus.mw_flush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2-3 time units after each rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        nrst = 1'b0;
        {id_rs1, id_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_rs1_en, id_rs2_en, ex_we, ex_is_load, ex_busy, ex_redirect} = '0;
        {mem_we, wb_we, icache_miss} = '0;
        step();
        step();
        #1;
        chk("rst_ctl", ctl, C_NORMAL);
        chk("rst_fwd1", bus.fwd_sel1, 0);
        chk("rst_fwd2", bus.fwd_sel2, 0);
        chk("rst_lu_cnt", bus.lu_stall_cnt, 0);
        chk("rst_miss_cnt", bus.miss_stall_cnt, 0);
        nrst = 1'b1;
        step();

        // Forwarding: EXE reads x5 (rs1) and x9 (rs2)
        id_rs1 = 5; id_rs2 = 9;
        step();
        mem_rd = 5; mem_we = 1; #1;
        chk("fwd_mem", bus.fwd_sel1, 2);
        chk("fwd_mem_rs2", bus.fwd_sel2, 0);
        step();
        mem_we = 0; wb_rd = 5; wb_we = 1; #1;
        chk("fwd_wb", bus.fwd_sel1, 1);
        step();
        mem_we = 1; #1;
        chk("fwd_mem_prio", bus.fwd_sel1, 2);
        step();
        mem_rd = 9; wb_rd = 9; mem_we = 0; #1;
        chk("fwd_wb_rs2", bus.fwd_sel2, 1);
        chk("fwd_rs1_none", bus.fwd_sel1, 0);
        id_rs1 = 0;
        step();
        mem_rd = 0; mem_we = 1; wb_rd = 0; wb_we = 1; #1;
        chk("fwd_x0", bus.fwd_sel1, 0);
        mem_we = 0; wb_we = 0; id_rs2 = 0;
        step();

        // Load-use on x7 via rs2
        id_rs2 = 7; id_rs2_en = 1; ex_is_load = 1; ex_we = 1; ex_rd = 7; #1;
        chk("lu_ctl", ctl, C_LU);
        step();
        ex_is_load = 0; ex_we = 0; ex_rd = 0; mem_rd = 7; mem_we = 1; #1;
        chk("lu_after", ctl, C_NORMAL);
        chk("lu_bubble_fwd", bus.fwd_sel2, 0);
        chk("lu_cnt1", bus.lu_stall_cnt, PERF ? 32'd1 : 32'd0);
        step();
        mem_we = 0; mem_rd = 0; wb_rd = 7; wb_we = 1; #1;
        chk("lu_wb_fwd", bus.fwd_sel2, 1);
        wb_we = 0; wb_rd = 0; id_rs2 = 0; id_rs2_en = 0;
        step();

        // Redirect overrides a simultaneous load-use
        ex_is_load = 1; ex_we = 1; ex_rd = 3; id_rs1 = 3; id_rs1_en = 1; ex_redirect = 1; #1;
        chk("redir_ctl", ctl, C_REDIR);
        step();
        ex_is_load = 0; ex_we = 0; ex_rd = 0; id_rs1_en = 0; id_rs1 = 0; ex_redirect = 0; #1;
        chk("redir_lu_cnt", bus.lu_stall_cnt, PERF ? 32'd1 : 32'd0);

        // I-cache miss: 3 cycles requested -> 4 frozen + 1 replay
        for (int i = 0; i < 3; i++) begin
            icache_miss = 1; #1;
            chk($sformatf("miss_frz%0d", i), ctl, C_FROZEN);
            step();
        end
        icache_miss = 0; #1;
        chk("miss_drop_frz", ctl, C_FROZEN);
        step();
        #1;
        chk("miss_replay", ctl, C_REPLAY);
        step();
        #1;
        chk("miss_run", ctl, C_NORMAL);
        chk("miss_cnt5", bus.miss_stall_cnt, PERF ? 32'd5 : 32'd0);

        // Redirect while in MISS returns straight to RUN
        icache_miss = 1;
        step();
        ex_redirect = 1; #1;
        chk("miss_redir", ctl, C_REDIR);
        step();
        ex_redirect = 0; icache_miss = 0; #1;
        chk("miss_redir_run", ctl, C_NORMAL);

        // Busy holds the FSM even with a miss pending
        ex_busy = 1; icache_miss = 1; #1;
        chk("busy_hold_ctl", ctl, C_BUSY);
        step();
        ex_busy = 0; icache_miss = 0; #1;
        chk("busy_hold_fsm", ctl, C_NORMAL);
        step();
        for (int i = 0; i < 3; i++) begin
            ex_busy = 1; icache_miss = 1; #1;
            chk($sformatf("busy%0d", i), ctl, C_BUSY);
            step();
        end
        ex_busy = 0; #1;
        chk("busy_then_frz", ctl, C_FROZEN);
        step();
        icache_miss = 0; #1;
        chk("busy_miss_frz", ctl, C_FROZEN);
        step();
        #1;
        chk("busy_miss_replay", ctl, C_REPLAY);
        step();
        #1;
        chk("busy_miss_run", ctl, C_NORMAL);
        chk("miss_cnt9", bus.miss_stall_cnt, PERF ? 32'd9 : 32'd0);

        // Reset in the middle of a miss
        icache_miss = 1;
        step();
        nrst = 0;
        step();
        nrst = 1; icache_miss = 0; #1;
        chk("rst_mid_miss", ctl, C_NORMAL);
        chk("rst_mid_lu_cnt", bus.lu_stall_cnt, 0);
        chk("rst_mid_miss_cnt", bus.miss_stall_cnt, 0);

        // 20 load-use stall cycles: 4-bit counter saturates
        ex_is_load = 1; ex_we = 1; ex_rd = 4; id_rs1 = 4; id_rs1_en = 1;
        for (int i = 0; i < 20; i++) step();
        ex_is_load = 0; ex_we = 0; ex_rd = 0; id_rs1 = 0; id_rs1_en = 0; #1;
        chk("sat_lu_cnt", bus_sat.lu_stall_cnt, PERF ? 32'd15 : 32'd0);
        chk("lu_cnt20", bus.lu_stall_cnt, PERF ? 32'd20 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
